// File: rtl/bf_stream_pkg.sv
// bf_stream_pkg: shared constants, TX launcher state type and the level-width
// helper used by the byte-stream bridge, its interface and its FIFOs.
package bf_stream_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int RX_DEPTH_DEF = 16;
    localparam int TX_DEPTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT
    } tx_state_e;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/bf_stream_bridge_if.sv
// bf_stream_bridge_if: all non-clock signals of the byte-stream bridge.
//   UART side : rx_data/new_rx in, tx_data/tx_send out, tx_busy in
//   Core side : core_rx_* (bridge -> core), core_tx_* (core -> bridge)
//   Status    : rx_level, tx_level, rx_overflow
// Modports: slave = bridge view, master = surrounding system view.
interface bf_stream_bridge_if
    import bf_stream_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int RX_DEPTH = RX_DEPTH_DEF,
    parameter int TX_DEPTH = TX_DEPTH_DEF
);
    logic [DATA_W-1:0]          rx_data;
    logic                       new_rx;
    logic [DATA_W-1:0]          tx_data;
    logic                       tx_send;
    logic                       tx_busy;
    logic [DATA_W-1:0]          core_rx_data;
    logic                       core_rx_valid;
    logic                       core_rx_ready;
    logic [DATA_W-1:0]          core_tx_data;
    logic                       core_tx_valid;
    logic                       core_tx_ready;
    logic [lvl_w(RX_DEPTH)-1:0] rx_level;
    logic [lvl_w(TX_DEPTH)-1:0] tx_level;
    logic                       rx_overflow;

    modport slave (
        input  rx_data, new_rx, tx_busy, core_rx_ready, core_tx_data, core_tx_valid,
        output tx_data, tx_send, core_rx_data, core_rx_valid, core_tx_ready,
               rx_level, tx_level, rx_overflow
    );

    modport master (
        output rx_data, new_rx, tx_busy, core_rx_ready, core_tx_data, core_tx_valid,
        input  tx_data, tx_send, core_rx_data, core_rx_valid, core_tx_ready,
               rx_level, tx_level, rx_overflow
    );
endinterface

// File: rtl/bf_sync_fifo.sv
// bf_sync_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst            : clock, synchronous active-high reset
//   push_i, wdata_i     : write request and data (ignored when full unless popping)
//   pop_i               : consume head (ignored when empty)
//   rdata_o             : head word, valid while !empty_o
//   full_o, empty_o     : status
//   level_o             : occupancy 0..DEPTH
// DEPTH must be a power of two >= 2; pointers carry one extra wrap bit.
module bf_sync_fifo
    import bf_stream_pkg::*;
#(
    parameter int WIDTH = DATA_W_DEF,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        wdata_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        rdata_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [lvl_w(DEPTH)-1:0] level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             do_push, do_pop;

    assign level_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = (level_o == (AW+1)'(DEPTH));
    assign empty_o = (level_o == '0);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/bf_stream_bridge.sv
// bf_stream_bridge: buffered byte-stream bridge between the UART byte
// interface and the interpreter core.
//   clk, rst : clock, synchronous active-high reset
//   bus      : bf_stream_bridge_if.slave (UART side, core side, status)
// RX bytes are queued for the core with valid/ready; core bytes are queued and
// launched to the UART one at a time by a small IDLE/SEND/WAIT pacer.
// Optional build macro BF_STREAM_ECHO_EN: every accepted RX byte is also
// queued for transmit (local echo), taking priority over the core that cycle.
module bf_stream_bridge
    import bf_stream_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int RX_DEPTH = RX_DEPTH_DEF,
    parameter int TX_DEPTH = TX_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    bf_stream_bridge_if.slave bus
);
    logic              rx_full, rx_empty, rx_pop, rx_ok;
    logic              tx_full, tx_empty, tx_pop, tx_push, tx_rdy_base;
    logic [DATA_W-1:0] tx_wdata, tx_head;
    logic              rx_ovf_q;

    tx_state_e         state_q, state_d;
    logic              tx_send_q, tx_send_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;

    // ---------------- RX path ----------------
    assign rx_pop = !rx_empty && bus.core_rx_ready;
    assign rx_ok  = bus.new_rx && (!rx_full || rx_pop);

    bf_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.new_rx),
        .wdata_i (bus.rx_data),
        .pop_i   (rx_pop),
        .rdata_o (bus.core_rx_data),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .level_o (bus.rx_level)
    );

    assign bus.core_rx_valid = !rx_empty;

    // UART strobes cannot be stalled, so a drop is recorded until reset.
    always_ff @(posedge clk) begin
        if (rst) rx_ovf_q <= 1'b0;
        else if (bus.new_rx && !rx_ok) rx_ovf_q <= 1'b1;
    end
    assign bus.rx_overflow = rx_ovf_q;

    // ---------------- TX path ----------------
    assign tx_rdy_base = !tx_full || tx_pop;

`ifdef BF_STREAM_ECHO_EN
    // Echo owns the TX write port whenever a UART byte arrives; if the TX
    // FIFO has no room the FIFO itself discards the echo.
    assign bus.core_tx_ready = tx_rdy_base && !bus.new_rx;
    assign tx_push  = rx_ok || (bus.core_tx_valid && bus.core_tx_ready);
    assign tx_wdata = rx_ok ? bus.rx_data : bus.core_tx_data;
`else
    assign bus.core_tx_ready = tx_rdy_base;
    assign tx_push  = bus.core_tx_valid && bus.core_tx_ready;
    assign tx_wdata = bus.core_tx_data;
`endif

    bf_sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (tx_push),
        .wdata_i (tx_wdata),
        .pop_i   (tx_pop),
        .rdata_o (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .level_o (bus.tx_level)
    );

    // ---------------- TX launcher ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tx_send_q <= 1'b0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            tx_send_q <= tx_send_d;
            tx_data_q <= tx_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tx_send_d = 1'b0;
        tx_data_d = tx_data_q;
        tx_pop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!tx_empty && !bus.tx_busy) begin
                    tx_pop    = 1'b1;
                    tx_send_d = 1'b1;
                    tx_data_d = tx_head;
                    state_d   = SEND;
                end
            end
            // tx_send is high during SEND; the UART raises tx_busy one cycle
            // later, so skip sampling it here.
            SEND:    state_d = WAIT;
            WAIT:    if (!bus.tx_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.tx_send = tx_send_q;
    assign bus.tx_data = tx_data_q;

endmodule

// File: doc/bf_stream_bridge.md
Name: bf_stream_bridge

Overview:
- Parametrised, buffered byte-stream bridge between the AVR UART byte interface and the interpreter core.
- Replaces direct wiring of rx_data/new_rx and tx_data/tx_send/tx_busy.
- Adds RX and TX FIFOs, valid/ready flow control on the core side, and a paced TX launcher.
- Adds overflow detection and fill-level reporting.

Parameters:
- DATA_W, 8, stream word width in bits.
- RX_DEPTH, 16, RX FIFO entries; power of two, minimum 2.
- TX_DEPTH, 16, TX FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- rx_data  in  DATA_W  byte from UART receiver.
- new_rx  in  1  one-cycle strobe, rx_data valid; cannot be back-pressured.
- tx_data  out  DATA_W  byte to UART transmitter.
- tx_send  out  1  one-cycle launch strobe.
- tx_busy  in  1  transmitter busy or blocked.
- core_rx_data  out  DATA_W  head of RX FIFO.
- core_rx_valid  out  1  RX FIFO non-empty.
- core_rx_ready  in  1  core consumes head.
- core_tx_data  in  DATA_W  byte from core.
- core_tx_valid  in  1  core offers byte.
- core_tx_ready  out  1  TX FIFO can accept.
- rx_level  out  $clog2(RX_DEPTH)+1  RX occupancy.
- tx_level  out  $clog2(TX_DEPTH)+1  TX occupancy.
- rx_overflow  out  1  sticky: an RX byte was dropped.

Behaviour:
- Reset state:
  - Both FIFOs empty; all levels 0.
  - tx_send=0, tx_data=0, rx_overflow=0.
  - core_rx_valid=0; core_tx_ready=1.
  - TX FSM in IDLE.
  - Reset mid-transfer discards all buffered data; a byte already launched is not recalled.
- FIFOs:
  - Synchronous, first-word-fall-through.
  - Write at clk edge when push accepted; data visible on the read side the next cycle.
  - Pointers wrap modulo depth; level = writes − reads.
- RX path:
  - new_rx pushes rx_data.
  - Full with no pop in the same cycle: byte dropped, rx_overflow set (cleared only by rst).
  - Full with a pop in the same cycle: push accepted, level unchanged.
  - Pop when core_rx_valid && core_rx_ready.
- Core TX:
  - core_tx_ready = !tx_full || tx_pop_this_cycle.
  - Push when core_tx_valid && core_tx_ready.
- TX launcher FSM:
  - IDLE: if TX FIFO non-empty and !tx_busy, register head into tx_data, pulse tx_send for one cycle, pop FIFO → SEND.
  - SEND: tx_send=0; unconditionally → WAIT. Covers the one-cycle lag before tx_busy rises.
  - WAIT: when !tx_busy → IDLE.
  - Minimum spacing between tx_send pulses is 3 cycles.
  - tx_data holds its value until the next launch.
- Simultaneous push and pop on either FIFO: both honoured, level unchanged.
- Empty with a push in the same cycle: no pop that cycle; valid rises next cycle. No bypass.
- Latency:
  - new_rx → core_rx_valid: 1 cycle.
  - core push into empty TX FIFO → tx_send: 2 cycles, given tx_busy=0.

Optional Feature:
- Macro: BF_STREAM_ECHO_EN.
- Defined:
  - Every accepted RX byte is also pushed into the TX FIFO, for a local terminal echo.
  - In a cycle with new_rx, the echo has priority: core_tx_ready is forced 0.
  - If the TX FIFO is full, the echo is dropped silently; the RX push is unaffected.
- Undefined: no echo logic; core_tx_ready follows the base rule.

Decomposition:
- Package bf_stream_pkg:
  - Default width/depth constants.
  - TX FSM state enum (IDLE, SEND, WAIT).
  - Level-width function.
- Sub-module bf_sync_fifo:
  - Parameters WIDTH and DEPTH.
  - Push, pop, full, empty, level; registered pointers.
  - Instantiated twice.
- The TX launcher FSM stays in the top module.

Test Plan:
- Reset then idle: after rst for 2 cycles, all levels 0, tx_send never pulses over 50 cycles, core_tx_ready=1.
- RX ordering: new_rx with 0x41, 0x42, 0x43 on consecutive cycles, core_rx_ready=1 → core sees 0x41, 0x42, 0x43 in order, each 1 cycle after its strobe; rx_level peaks at 1.
- RX overflow: 17 strobes with core_rx_ready=0, DEPTH=16 → rx_level=16, rx_overflow=1, first 16 bytes intact, 17th lost. Then a strobe coinciding with a pop is accepted.
- TX pacing: push 0x10, 0x20 with tx_busy held 1 for 10 cycles after each launch → tx_send pulses exactly twice, first 2 cycles after push, second only once tx_busy has fallen, tx_data correct at each pulse.
- TX full back-pressure: hold tx_busy=1, push 16 bytes → core_tx_ready=0, tx_level=16; release tx_busy → all 16 bytes transmitted in order.
- Echo (BF_STREAM_ECHO_EN): new_rx 0x61 coinciding with core_tx_valid → core_tx_ready=0 that cycle; tx_send carries 0x61 first, core byte next.
